// File: rtl/sme_share_codec.sv
// ---------------------------------------------------------------------------
// sme_share_codec
//
// Share-serial boolean masking unit. Converts a plain word into N shares
// (mask), folds N shares back into a plain word (unmask), or re-randomises an
// existing sharing (remask). Exactly one share is touched per cycle, so no
// cycle ever combines more than two shares in a single XOR.
//
// Ports
//   g_clk, g_resetn  clock, synchronous active-low reset
//   flush            abort the current operation and clear the share register
//   smectl_d         requested share count, clamped to 2..SMAX on accept
//   valid / ready    request held until the one-cycle ready pulse
//   op_mask/op_unmask/op_remask  one-hot operation select
//   rs1              input shares (rs1[0] is the plain value for mask)
//   rng_req          a random word is wanted this cycle
//   rng_valid, rng   random word source, consumed when rng_req && rng_valid
//   rd               result shares, taken directly from the share register
// ---------------------------------------------------------------------------
module sme_share_codec #(
    parameter int XLEN = 32,
    parameter int SMAX = 3
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       flush,
    input  logic [3:0]                 smectl_d,
    input  logic                       valid,
    output logic                       ready,
    input  logic                       op_mask,
    input  logic                       op_unmask,
    input  logic                       op_remask,
    input  logic [SMAX-1:0][XLEN-1:0]  rs1,
    output logic                       rng_req,
    input  logic                       rng_valid,
    input  logic [XLEN-1:0]            rng,
    output logic [SMAX-1:0][XLEN-1:0]  rd
);

    localparam logic [3:0] SMAX_W = 4'(SMAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 idx_q, idx_d;
    logic [3:0]                 n_q, n_d;
    logic                       rnd_op_q, rnd_op_d;   // mask/remask consume randomness
    logic [SMAX-1:0][XLEN-1:0]  sh_q, sh_d;
    logic                       last_step;

    function automatic logic [3:0] clamp_n(input logic [3:0] s);
        if (s < 4'd2) begin
            return 4'd2;
        end else if (s > SMAX_W) begin
            return SMAX_W;
        end else begin
            return s;
        end
    endfunction

    assign last_step = (idx_q == (n_q - 4'd1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        rnd_op_d = rnd_op_q;
        sh_d     = sh_q;
        ready    = 1'b0;
        rng_req  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid && (op_mask || op_unmask || op_remask)) begin
                    n_d      = clamp_n(smectl_d);
                    rnd_op_d = op_mask || op_remask;
                    idx_d    = 4'd1;
                    state_d  = S_RUN;
                    // Mask starts from the plain value in share 0 and zeros
                    // elsewhere; shares at or above N are always held at 0.
                    for (int i = 0; i < SMAX; i++) begin
                        if (i == 0) begin
                            sh_d[i] = rs1[0];
                        end else if ((4'(i) < n_d) && !op_mask) begin
                            sh_d[i] = rs1[i];
                        end else begin
                            sh_d[i] = '0;
                        end
                    end
                end
            end

            S_RUN: begin
                if (!valid) begin
                    state_d = S_IDLE;
                end else if (rnd_op_q) begin
                    rng_req = 1'b1;
                    if (rng_valid) begin
                        // Same word enters share idx and share 0, so the
                        // XOR of all shares is preserved.
                        for (int i = 1; i < SMAX; i++) begin
                            if (4'(i) == idx_q) begin
                                sh_d[i] = sh_q[i] ^ rng;
                            end
                        end
                        sh_d[0] = sh_q[0] ^ rng;
                        idx_d   = idx_q + 4'd1;
                        if (last_step) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    for (int i = 1; i < SMAX; i++) begin
                        if (4'(i) == idx_q) begin
                            sh_d[0] = sh_q[0] ^ sh_q[i];
                            sh_d[i] = '0;
                        end
                    end
                    idx_d = idx_q + 4'd1;
                    if (last_step) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                ready   = valid;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a request accepted this cycle.
        if (flush) begin
            state_d = S_IDLE;
            sh_d    = '0;
            ready   = 1'b0;
            rng_req = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            n_q      <= 4'd2;
            rnd_op_q <= 1'b0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            rnd_op_q <= rnd_op_d;
            sh_q     <= sh_d;
        end
    end

    assign rd = sh_q;

endmodule

// File: tb/tb_sme_share_codec.sv
`timescale 1ns/1ps
module tb_sme_share_codec;
    localparam int XLEN = 32;
    localparam int SMAX = 3;
    typedef logic [SMAX-1:0][XLEN-1:0] vec_t;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            flush = 1'b0;
    logic [3:0]      smectl_d = 4'd3;
    logic            valid = 1'b0;
    logic            ready;
    logic            op_mask = 1'b0;
    logic            op_unmask = 1'b0;
    logic            op_remask = 1'b0;
    vec_t            rs1 = '0;
    logic            rng_req;
    logic            rng_valid = 1'b0;
    logic [XLEN-1:0] rng = '0;
    vec_t            rd;

    int checks = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    sme_share_codec #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .smectl_d(smectl_d),
        .valid(valid), .ready(ready), .op_mask(op_mask), .op_unmask(op_unmask),
        .op_remask(op_remask), .rs1(rs1), .rng_req(rng_req), .rng_valid(rng_valid),
        .rng(rng), .rd(rd)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              m_live = 1'b0;
    bit              m_busy = 1'b0;
    bit              m_rdk = 1'b0;    // expected rd is known while idle
    bit              m_rand = 1'b0;
    int              m_op = 0;        // 0 mask, 1 unmask, 2 remask
    int              m_n = 2;
    int              m_cnt = 0;       // random words consumed so far
    int              m_el = 0;        // unmask steps done so far
    vec_t            m_in = '0;
    vec_t            m_rd = '0;
    logic [XLEN-1:0] m_rw [16];

    function automatic int clampn(input int s);
        if (s < 2) return 2;
        if (s > SMAX) return SMAX;
        return s;
    endfunction

    // Final share vector from the inputs and the random words drawn.
    function automatic vec_t result();
        vec_t r;
        logic [XLEN-1:0] acc;
        r = '0;
        if (m_op == 1) begin
            acc = '0;
            for (int i = 0; i < m_n; i++) acc = acc ^ m_in[i];
            r[0] = acc;
        end else begin
            acc = m_in[0];
            for (int i = 1; i < m_n; i++) begin
                r[i] = ((m_op == 0) ? '0 : m_in[i]) ^ m_rw[i-1];
                acc  = acc ^ m_rw[i-1];
            end
            r[0] = acc;
        end
        return r;
    endfunction

    always @(negedge g_clk) begin : cmp
        bit fin, e_ready, e_req;
        fin     = m_busy && (m_rand ? (m_cnt == m_n - 1) : (m_el == m_n - 1));
        e_ready = fin && valid && !flush;
        e_req   = m_busy && m_rand && !fin && valid && !flush;
        if (m_live) begin
            chk("ready", 128'(ready), 128'(e_ready));
            chk("rng_req", 128'(rng_req), 128'(e_req));
            if (e_ready) chk("rd_result", 128'(rd), 128'(result()));
            else if (!m_busy && m_rdk) chk("rd_hold", 128'(rd), 128'(m_rd));
        end
        // advance to the state the coming edge will produce
        if (!g_resetn) begin
            m_live = 1'b1; m_busy = 1'b0; m_rd = '0; m_rdk = 1'b1;
        end else if (flush) begin
            m_busy = 1'b0; m_rd = '0; m_rdk = 1'b1;
        end else if (!m_busy) begin
            if (valid && (op_mask || op_unmask || op_remask)) begin
                m_busy = 1'b1;
                m_rand = !op_unmask;
                m_op   = op_mask ? 0 : (op_unmask ? 1 : 2);
                m_n    = clampn(int'(smectl_d));
                m_in   = rs1;
                m_cnt  = 0;
                m_el   = 0;
            end
        end else if (!valid) begin
            m_busy = 1'b0; m_rdk = 1'b0;
        end else if (fin) begin
            m_busy = 1'b0; m_rd = result(); m_rdk = 1'b1;
        end else if (m_rand) begin
            if (rng_valid) begin
                m_rw[m_cnt] = rng;
                m_cnt++;
            end
        end else begin
            m_el++;
        end
    end

    // ---------------- directed transaction driver ----------------
    task automatic do_op(input int op, input logic [3:0] sc, input vec_t in,
                         input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1,
                         input int stalls_in, output vec_t res, output int lat,
                         output bit saw_req);
        int ptr;
        int stalls;
        ptr = 0; stalls = stalls_in; lat = 0; saw_req = 1'b0; res = '0;
        @(posedge g_clk); #1;
        valid = 1'b1; op_mask = (op == 0); op_unmask = (op == 1); op_remask = (op == 2);
        smectl_d = sc; rs1 = in; rng_valid = 1'b0; rng = r0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge g_clk);
            if (rng_req) saw_req = 1'b1;
            if (rng_req && rng_valid) ptr++;
            else if (rng_req) stalls--;
            if (ready) begin
                lat = c; res = rd;
                break;
            end
            @(posedge g_clk); #1;
            smectl_d  = 4'($urandom_range(0, 15));   // must not affect a running op
            rng_valid = (stalls <= 0);
            rng       = (ptr == 0) ? r0 : r1;
        end
        @(posedge g_clk); #1;
        valid = 1'b0; op_mask = 1'b0; op_unmask = 1'b0; op_remask = 1'b0; rng_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, res;
        int lat;
        bit sr;

        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        chk("reset_rd", 128'(rd), 128'(0));
        chk("reset_ready", 128'(ready), 128'(0));
        chk("reset_rng_req", 128'(rng_req), 128'(0));

        // 1: N=3 mask
        v = '0; v[0] = 32'hDEADBEEF; v[1] = 32'h12345678; v[2] = 32'h9ABCDEF0;
        do_op(0, 4'd3, v, 32'h11111111, 32'h22222222, 0, res, lat, sr);
        chk("t1_lat", 128'(lat), 128'(4));
        chk("t1_rd0", 128'(res[0]), 128'(32'hED9E8DDC));
        chk("t1_rd1", 128'(res[1]), 128'(32'h11111111));
        chk("t1_rd2", 128'(res[2]), 128'(32'h22222222));
        chk("t1_xor", 128'(res[0] ^ res[1] ^ res[2]), 128'(32'hDEADBEEF));

        // 2: N=3 unmask
        v[0] = 32'hED9E8DDC; v[1] = 32'h11111111; v[2] = 32'h22222222;
        do_op(1, 4'd3, v, 32'h0, 32'h0, 0, res, lat, sr);
        chk("t2_lat", 128'(lat), 128'(4));
        chk("t2_rng_req_seen", 128'(sr), 128'(0));
        chk("t2_rd", 128'(res), {32'h0, 32'h0, 32'h0, 32'hDEADBEEF});

        // 3: N=2 remask with two stalled rng cycles
        v[0] = 32'hA5A5A5A5; v[1] = 32'h0F0F0F0F; v[2] = 32'hCAFEF00D;
        do_op(2, 4'd2, v, 32'hFFFFFFFF, 32'h0, 2, res, lat, sr);
        chk("t3_lat", 128'(lat), 128'(5));
        chk("t3_rd", 128'(res), {32'h0, 32'h0, 32'hF0F0F0F0, 32'h5A5A5A5A});
        chk("t3_xor", 128'(res[0] ^ res[1]), 128'(32'hAAAAAAAA));

        // 4: share-count clamping
        v[0] = 32'h12340000; v[1] = 32'h0000FFFF; v[2] = 32'h77777777;
        do_op(1, 4'd0, v, 32'h0, 32'h0, 0, res, lat, sr);
        chk("t4a_lat", 128'(lat), 128'(3));
        chk("t4a_rd", 128'(res), {32'h0, 32'h0, 32'h0, 32'h1234FFFF});
        do_op(1, 4'd9, v, 32'h0, 32'h0, 0, res, lat, sr);
        chk("t4b_lat", 128'(lat), 128'(4));
        chk("t4b_rd", 128'(res), {32'h0, 32'h0, 32'h0, 32'h65438888});

        // 5: flush during RUN of a mask
        @(posedge g_clk); #1;
        valid = 1'b1; op_mask = 1'b1; smectl_d = 4'd3; rs1 = v; rng_valid = 1'b1; rng = 32'h5555AAAA;
        @(posedge g_clk); #1 flush = 1'b1;
        @(negedge g_clk);
        chk("t5_ready_in_flush", 128'(ready), 128'(0));
        @(posedge g_clk); #1;
        flush = 1'b0; valid = 1'b0; op_mask = 1'b0;
        @(negedge g_clk);
        chk("t5_rd_cleared", 128'(rd), 128'(0));
        chk("t5_ready", 128'(ready), 128'(0));
        v[0] = 32'h0BADF00D;
        do_op(0, 4'd2, v, 32'h01010101, 32'h0, 0, res, lat, sr);
        chk("t5_after_lat", 128'(lat), 128'(3));
        chk("t5_after_rd", 128'(res), {32'h0, 32'h0, 32'h01010101, 32'h0AACF10C});

        // 6a: valid falls mid-RUN
        @(posedge g_clk); #1;
        valid = 1'b1; op_remask = 1'b1; smectl_d = 4'd3; rs1 = v; rng_valid = 1'b0;
        @(posedge g_clk); #1 valid = 1'b0;
        @(negedge g_clk);
        chk("t6a_rng_req", 128'(rng_req), 128'(0));
        @(posedge g_clk); #1 op_remask = 1'b0;
        @(negedge g_clk);
        chk("t6a_ready", 128'(ready), 128'(0));
        chk("t6a_rng_req_idle", 128'(rng_req), 128'(0));

        // 6b: reset mid-RUN
        @(posedge g_clk); #1;
        valid = 1'b1; op_mask = 1'b1; rs1 = v; rng_valid = 1'b1; rng = 32'h3C3C3C3C;
        @(posedge g_clk); #1 g_resetn = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1; valid = 1'b0; op_mask = 1'b0;
        @(negedge g_clk);
        chk("t6b_rd", 128'(rd), 128'(0));
        chk("t6b_ready", 128'(ready), 128'(0));
        chk("t6b_rng_req", 128'(rng_req), 128'(0));

        // randomized traffic, checked cycle by cycle by the model
        for (int t = 0; t < 300; t++) begin
            int opsel;
            opsel = $urandom_range(0, 9);
            @(posedge g_clk); #1;
            valid = 1'b1;
            op_mask   = (opsel >= 1 && opsel <= 3);
            op_unmask = (opsel >= 4 && opsel <= 6);
            op_remask = (opsel >= 7);
            smectl_d  = 4'($urandom_range(0, 15));
            for (int k = 0; k < SMAX; k++) rs1[k] = $urandom;
            for (int c = 0; c < 60; c++) begin
                @(negedge g_clk);
                if (ready || flush || !valid) break;
                if (opsel == 0 && c >= 2) break;
                @(posedge g_clk); #1;
                rng_valid = ($urandom_range(0, 9) < 7);
                rng       = $urandom;
                flush     = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 49) == 0) valid = 1'b0;
                smectl_d  = 4'($urandom_range(0, 15));
            end
            @(posedge g_clk); #1;
            valid = 1'b0; op_mask = 1'b0; op_unmask = 1'b0; op_remask = 1'b0;
            flush = 1'b0; rng_valid = 1'($urandom_range(0, 1));
        end

        repeat (3) @(posedge g_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
